// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code lock.
// State encoding, digit range and nibble width.
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } lock_state_e;

  localparam logic [3:0] DIGIT_MIN = 4'd1;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam int unsigned NIBBLE = 4;

endpackage

// File: rtl/lock_timer.sv
// Loadable 32-bit down-counter shared by entry, open and lockout.
// Loads value-1 and holds at zero; expired flags zero.
module lock_timer (
  input  logic        hwclk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] cnt_q;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val - 32'd1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lock_code_checker.sv
// Keypad code checker: collects digits, compares, unlocks,
// and enforces a lockout after repeated failures.
module lock_code_checker
  import lock_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [31:0] UNLOCK_CYCLES  = 32'd60000000,
  parameter logic [31:0] ENTRY_TIMEOUT  = 32'd120000000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd360000000
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       unlocked,
  output logic       error_pulse,
  output logic       locked_out,
  output logic [2:0] digit_count
);

  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] MAX_F = FW'(MAX_FAILS);
  localparam logic [2:0] LEN = 3'(CODE_LEN);
  localparam logic [15:0] MASK =
    16'hFFFF >> (16 - CODE_LEN * NIBBLE);

  lock_state_e state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0] cnt_q, cnt_d;
  logic [FW-1:0] fails_q, fails_d;
  logic unl_q, err_q, lko_q;
  logic tload, expired;
  logic [31:0] tval;
  logic key_ok, match;

  assign key_ok = key_valid
    && (key_digit >= DIGIT_MIN)
    && (key_digit <= DIGIT_MAX);
  assign match = ((buf_q ^ CODE) & MASK) == '0;

  lock_timer u_timer (
    .hwclk    (hwclk),
    .rst_n    (rst_n),
    .load     (tload),
    .load_val (tval),
    .expired  (expired)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fails_d = fails_q;
    tload   = 1'b0;
    tval    = ENTRY_TIMEOUT;
    unique case (state_q)
      S_IDLE: begin
        if (key_ok) begin
          buf_d   = {buf_q[11:0], key_digit};
          cnt_d   = 3'd1;
          tload   = 1'b1;
          state_d = (LEN == 3'd1) ? S_CHECK : S_ENTRY;
        end
      end
      S_ENTRY: begin
        // a key in the expiry cycle wins and reloads
        if (key_ok) begin
          buf_d = {buf_q[11:0], key_digit};
          cnt_d = cnt_q + 3'd1;
          tload = 1'b1;
          if (cnt_q + 3'd1 == LEN) state_d = S_CHECK;
        end else if (expired) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (match) begin
          tload   = 1'b1;
          tval    = UNLOCK_CYCLES;
          fails_d = '0;
          state_d = S_OPEN;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_OPEN: begin
        if (expired) state_d = S_IDLE;
      end
      S_FAIL: begin
        if (fails_q != MAX_F) fails_d = fails_q + 1'b1;
        if (fails_d == MAX_F) begin
          tload   = 1'b1;
          tval    = LOCKOUT_CYCLES;
          state_d = S_LOCKOUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (expired) begin
          fails_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      fails_q <= '0;
      unl_q   <= 1'b0;
      err_q   <= 1'b0;
      lko_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fails_q <= fails_d;
      unl_q   <= (state_d == S_OPEN);
      err_q   <= (state_d == S_FAIL);
      lko_q   <= (state_d == S_LOCKOUT);
    end
  end

  assign unlocked    = unl_q;
  assign error_pulse = err_q;
  assign locked_out  = lko_q;
  assign digit_count = cnt_q;

endmodule
